// File: rtl/charge_session_timer.sv
// rtl/charge_session_timer.sv - Prescaled countdown timer for a charge session
module charge_session_timer #(
    parameter int          TICK_DIV = 50000000,
    parameter logic [11:0] DUR_STD  = 12'd1800,
    parameter logic [11:0] DUR_FAST = 12'd900
) (
    input  logic        clk,
    input  logic        nReset,
    input  logic        CounterEnable,
    input  logic [3:0]  Mode,
    input  logic        Pause,
    input  logic        Abort,
    output logic [11:0] PresentTime,
    output logic        Charging,
    output logic        Done,
    output logic [1:0]  State
);

    localparam int PW = $clog2(TICK_DIV);
    localparam logic [PW-1:0] TICK_LAST = PW'(TICK_DIV - 1);
    localparam logic [3:0] MODE_STD  = 4'b0001;
    localparam logic [3:0] MODE_FAST = 4'b0101;

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_RUN   = 2'b01,
        S_PAUSE = 2'b10,
        S_DONE  = 2'b11
    } state_t;

    state_t        state, state_n;
    logic [11:0]   time_q, time_n;
    logic [PW-1:0] presc, presc_n;
    logic          armed, armed_n;
    logic          tick;
    logic          charge_mode;

    assign tick        = (presc == TICK_LAST);
    assign charge_mode = (Mode == MODE_STD) || (Mode == MODE_FAST);

    always_ff @(posedge clk) begin
        if (!nReset) begin
            state  <= S_IDLE;
            time_q <= '0;
            presc  <= '0;
            armed  <= 1'b1;
        end else begin
            state  <= state_n;
            time_q <= time_n;
            presc  <= presc_n;
            armed  <= armed_n;
        end
    end

    always_comb begin
        state_n = state;
        time_n  = time_q;
        presc_n = presc;
        armed_n = armed;
        case (state)
            S_IDLE: begin
                // Re-arm only once the controller leaves a charging mode, so a
                // held enable cannot chain sessions back to back.
                if (!charge_mode) armed_n = 1'b1;
                if (Abort) armed_n = 1'b0;
                if (CounterEnable && armed && !Abort && charge_mode) begin
                    time_n  = (Mode == MODE_STD) ? DUR_STD : DUR_FAST;
                    presc_n = '0;
                    state_n = S_RUN;
                end
            end
            S_RUN: begin
                if (Abort) begin
                    time_n  = '0;
                    armed_n = 1'b0;
                    state_n = S_IDLE;
                end else if (Pause) begin
                    state_n = S_PAUSE;
                end else if (tick) begin
                    presc_n = '0;
                    if (time_q > 12'd1) begin
                        time_n = time_q - 12'd1;
                    end else begin
                        time_n  = '0;
                        armed_n = 1'b0;
                        state_n = S_DONE;
                    end
                end else begin
                    presc_n = presc + 1'b1;
                end
            end
            S_PAUSE: begin
                if (Abort) begin
                    time_n  = '0;
                    armed_n = 1'b0;
                    state_n = S_IDLE;
                end else if (!Pause) begin
                    state_n = S_RUN;
                end
            end
            S_DONE: begin
                time_n  = '0;
                armed_n = 1'b0;
                state_n = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase
    end

    assign PresentTime = time_q;
    assign Charging    = (state == S_RUN) || (state == S_PAUSE);
    assign Done        = (state == S_DONE);
    assign State       = state;

endmodule

// File: tb/tb_charge_session_timer.sv
// tb/tb_charge_session_timer.sv - Directed self-checking bench for charge_session_timer
module tb_charge_session_timer;

    logic        clk;
    logic        nReset;
    logic        CounterEnable;
    logic [3:0]  Mode;
    logic        Pause;
    logic        Abort;
    logic [11:0] PresentTime;
    logic        Charging;
    logic        Done;
    logic [1:0]  State;

    int tests_run;
    int tests_failed;

    charge_session_timer #(
        .TICK_DIV (4),
        .DUR_STD  (12'd3),
        .DUR_FAST (12'd2)
    ) dut (
        .clk           (clk),
        .nReset        (nReset),
        .CounterEnable (CounterEnable),
        .Mode          (Mode),
        .Pause         (Pause),
        .Abort         (Abort),
        .PresentTime   (PresentTime),
        .Charging      (Charging),
        .Done          (Done),
        .State         (State)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_out(input string tag, input int st, input int pt, input int chg, input int dn);
        check({tag, "_state"}, 32'(State), st);
        check({tag, "_time"}, 32'(PresentTime), pt);
        check({tag, "_charging"}, 32'(Charging), chg);
        check({tag, "_done"}, 32'(Done), dn);
    endtask

    initial begin
        tests_run     = 0;
        tests_failed  = 0;
        nReset        = 1'b0;
        CounterEnable = 1'b0;
        Mode          = 4'b0000;
        Pause         = 1'b0;
        Abort         = 1'b0;

        // Reset state
        step();
        check_out("reset", 0, 0, 0, 0);
        nReset = 1'b1;

        // Standard session: 3 s at 4 cycles per tick
        Mode = 4'b0001;
        CounterEnable = 1'b1;
        step();
        CounterEnable = 1'b0;
        check_out("std_start", 1, 3, 1, 0);
        for (int k = 1; k <= 11; k++) begin
            step();
            check("std_count_time", 32'(PresentTime), 3 - k / 4);
            check("std_count_state", 32'(State), 1);
        end
        step();
        check_out("std_done", 3, 0, 0, 1);
        step();
        check_out("std_idle", 0, 0, 0, 0);

        // Held enable in a charging mode must not retrigger
        CounterEnable = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            check("no_retrigger", 32'(State), 0);
        end
        Mode = 4'b0000;
        step();
        check("rearm_idle", 32'(State), 0);
        Mode = 4'b0001;
        step();
        CounterEnable = 1'b0;
        check_out("restart", 1, 3, 1, 0);

        // Abort mid-run once PresentTime reaches 2
        for (int k = 1; k <= 5; k++) step();
        check("abort_pre_time", 32'(PresentTime), 2);
        Abort = 1'b1;
        step();
        Abort = 1'b0;
        check_out("abort", 0, 0, 0, 0);
        for (int k = 0; k < 3; k++) begin
            step();
            check("abort_no_done", 32'(Done), 0);
        end
        Mode = 4'b0000;
        step();

        // Fast session with pause: count frozen for 10 cycles, completion at 8+10
        Mode = 4'b0101;
        CounterEnable = 1'b1;
        step();
        CounterEnable = 1'b0;
        check_out("fast_start", 1, 2, 1, 0);
        for (int k = 1; k <= 5; k++) step();
        check("fast_pre_pause", 32'(PresentTime), 1);
        Pause = 1'b1;
        for (int k = 6; k <= 14; k++) begin
            step();
            check("pause_state", 32'(State), 2);
            check("pause_time", 32'(PresentTime), 1);
        end
        check("pause_charging", 32'(Charging), 1);
        Pause = 1'b0;
        step();
        check_out("resume", 1, 1, 1, 0);
        step();
        step();
        check_out("resume_k17", 1, 1, 1, 0);
        step();
        check_out("fast_done", 3, 0, 0, 1);
        step();
        check("fast_idle", 32'(State), 0);

        // Non-charging mode ignored, and arms the timer
        Mode = 4'b0011;
        CounterEnable = 1'b1;
        step();
        check("mode_0011", 32'(State), 0);
        step();
        check("mode_0011_b", 32'(State), 0);

        // Reset during PAUSE
        Mode = 4'b0001;
        step();
        CounterEnable = 1'b0;
        check("pre_reset_run", 32'(State), 1);
        Pause = 1'b1;
        step();
        check("pre_reset_pause", 32'(State), 2);
        nReset = 1'b0;
        step();
        check_out("reset_in_pause", 0, 0, 0, 0);
        nReset = 1'b1;
        Pause = 1'b0;
        CounterEnable = 1'b1;
        step();
        CounterEnable = 1'b0;
        check_out("post_reset_start", 1, 3, 1, 0);

        // Pause on the exact tick cycle with PresentTime==1: tick discarded
        for (int k = 1; k <= 11; k++) step();
        check("edge_pre_time", 32'(PresentTime), 1);
        Pause = 1'b1;
        step();
        check_out("edge_pause", 2, 1, 1, 0);
        step();
        check_out("edge_pause_hold", 2, 1, 1, 0);
        Pause = 1'b0;
        step();
        check_out("edge_resume", 1, 1, 1, 0);
        step();
        check_out("edge_done", 3, 0, 0, 1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/charge_session_timer.md
Name: charge_session_timer

Overview:
- Downstream of the charge-station controller: it consumes CounterEnable and produces the 12-bit PresentTime that the controller monitors.
- On a start request in a charging mode, it loads a mode-dependent session length in seconds.
- It counts that length down once per prescaled tick, supports pause and abort, and signals completion.
- After a session ends it holds off restarting until the mode is cleared, so the controller's enable-at-zero behaviour cannot retrigger back-to-back sessions.

Parameters:
TICK_DIV, 50000000, clock cycles per one-second tick (>=2)
DUR_STD, 12'd1800, session length in seconds for Mode 4'b0001 (1..4095)
DUR_FAST, 12'd900, session length in seconds for Mode 4'b0101 (1..4095)

Ports:
clk  input  1  system clock, all logic on rising edge
nReset  input  1  reset, synchronous, active-low
CounterEnable  input  1  start request from controller
Mode  input  4  charging mode; 4'b0001 standard, 4'b0101 fast, others non-charging
Pause  input  1  level; freeze countdown while high
Abort  input  1  level; terminate session immediately
PresentTime  output  12  remaining seconds, registered
Charging  output  1  high in RUN and PAUSE
Done  output  1  one-cycle pulse on normal completion
State  output  2  00 IDLE, 01 RUN, 10 PAUSE, 11 DONE

Behaviour:
- Reset (nReset low at clk edge) sets:
  - State=IDLE, PresentTime=0, Done=0, Charging=0.
  - Prescaler=0, Armed=1.
  - Reset overrides all other inputs and may be asserted in any state.
- Prescaler width is $clog2(TICK_DIV). A tick is the cycle in RUN where the prescaler equals TICK_DIV-1. On a tick the prescaler wraps to 0; otherwise it increments by 1 in RUN.
- Armed flag:
  - Cleared on entry to DONE and on Abort.
  - Set on any IDLE cycle where Mode is not 0001 and not 0101.
- IDLE, start condition:
  - If CounterEnable=1, Armed=1, Mode==0001 and Abort=0: load PresentTime=DUR_STD, prescaler=0, go to RUN.
  - If CounterEnable=1, Armed=1, Mode==0101 and Abort=0: load PresentTime=DUR_FAST, prescaler=0, go to RUN.
  - Charging=1 from the first RUN cycle, i.e. one cycle after the start request.
- IDLE, no start: CounterEnable with any other Mode, or with Armed=0, is ignored.
- Mode is sampled only at start. Mode changes during RUN or PAUSE do not affect duration.
- RUN, priority Abort > Pause > tick:
  - Abort: go to IDLE, PresentTime=0, Armed=0, Done stays 0.
  - Pause: go to PAUSE. Prescaler and PresentTime hold, and a tick coinciding with Pause is discarded (no decrement).
  - Tick with PresentTime>1: decrement PresentTime by 1.
  - Tick with PresentTime==1: PresentTime=0, go to DONE.
  - PresentTime never underflows below 0.
- PAUSE:
  - Prescaler and PresentTime hold.
  - Abort: go to IDLE, as from RUN.
  - Pause low: go to RUN, resuming from the held prescaler value.
- DONE:
  - Lasts exactly one cycle with Done=1, Charging=0, PresentTime=0, Armed=0.
  - Then always go to IDLE.
  - Done is 0 in every other state.
- CounterEnable is ignored outside IDLE.

Test Plan:
- TICK_DIV=4, DUR_STD=3. Reset, then Mode=0001 with CounterEnable pulsed 1 cycle -> next cycle State=01, PresentTime=3. PresentTime reads 2, 1 and 0 at 4, 8 and 12 cycles after RUN entry. Done pulses 1 cycle with State=11, then State=00.
- Mode=0101, DUR_FAST=2, start -> PresentTime=2. Raise Pause after 5 RUN cycles for 10 cycles -> PresentTime frozen at 1, prescaler frozen. Release -> completion lands exactly 10 cycles later than the unpaused case.
- Mid-RUN Abort=1 with PresentTime=2 -> next cycle State=00, PresentTime=0, Charging=0, Done never pulses.
- After completion, hold Mode=0001 and CounterEnable=1 -> remains IDLE (Armed=0). Set Mode=0000 for 1 cycle, then back to 0001 -> session restarts with PresentTime=3.
- Mode=0011 with CounterEnable=1 -> stays IDLE. Separately, assert nReset=0 during PAUSE -> next edge State=00, PresentTime=0, Armed=1.
- Pause rising on the exact tick cycle with PresentTime=1 -> State=10, PresentTime stays 1 (no DONE).
